aes_tbox_lookup_pipe: RTL

- Parametrised AES encryption-round T-box lookup for NCOL 32-bit state columns at once.
- Each column yields four 32-bit partial words p0..p3; downstream XORs them with the round key.
- Adds what the single-column lookup lacks:
  - valid/ready flow control with backpressure;
  - a configurable extra pipeline stage;
  - a per-transfer final-round mode that emits SubBytes-only partials (no MixColumns).
- Sits between the round-state register and the AddRoundKey XOR tree.

---
 rtl/aes_tbox_lookup_pipe.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/aes_tbox_lookup_pipe.sv
// AES encryption-round T-box lookup for NCOL state columns with valid/ready flow control,
// an optional second register stage and a per-transfer final-round (SubBytes-only) mode.
module aes_tbox_lookup_pipe #(
  parameter int NCOL = 1,
  parameter int PIPE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_final,
  input  logic [32*NCOL-1:0]   in_state,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_final,
  output logic [32*NCOL-1:0]   out_p0,
  output logic [32*NCOL-1:0]   out_p1,
  output logic [32*NCOL-1:0]   out_p2,
  output logic [32*NCOL-1:0]   out_p3
);
  localparam int W = 32 * NCOL;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0 without a special case
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] t;
    logic [7:0] acc;
    t   = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      t   = gf_mul(t, t);
      acc = gf_mul(acc, t);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    logic [7:0] s;
    b = gf_inv(x);
    for (int i = 0; i < 8; i++)
      s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8];
    return s ^ 8'h63;
  endfunction

  // returns {p0, p1, p2, p3} for one column
  function automatic logic [127:0] col_lookup(input logic [31:0] col, input logic fin);
    logic [3:0][7:0] s;
    logic [3:0][7:0] s2;
    logic [3:0][7:0] s3;
    for (int k = 0; k < 4; k++) begin
      s[k]  = sbox(col[31-8*k -: 8]);
      s2[k] = xtime(s[k]);
      s3[k] = s2[k] ^ s[k];
    end
    if (fin)
      return {s[0], 24'h0, 8'h0, s[1], 16'h0, 16'h0, s[2], 8'h0, 24'h0, s[3]};
    return {s2[0], s[0],  s[0],  s3[0],
            s3[1], s2[1], s[1],  s[1],
            s[2],  s3[2], s2[2], s[2],
            s[3],  s[3],  s3[3], s2[3]};
  endfunction

  logic [W-1:0] lk_p0, lk_p1, lk_p2, lk_p3;

  for (genvar c = 0; c < NCOL; c++) begin : g_col
    logic [127:0] r;
    assign r = col_lookup(in_state[32*c +: 32], in_final);
    assign lk_p0[32*c +: 32] = r[127:96];
    assign lk_p1[32*c +: 32] = r[95:64];
    assign lk_p2[32*c +: 32] = r[63:32];
    assign lk_p3[32*c +: 32] = r[31:0];
  end

  logic         s1_valid, s1_final;
  logic [W-1:0] s1_p0, s1_p1, s1_p2, s1_p3;
  logic         s1_ready, nxt_ready;

  assign s1_ready = !s1_valid || nxt_ready;
  assign in_ready = !rst && s1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_final <= 1'b0;
      s1_p0    <= '0;
      s1_p1    <= '0;
      s1_p2    <= '0;
      s1_p3    <= '0;
    end else if (s1_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_final <= in_final;
        s1_p0    <= lk_p0;
        s1_p1    <= lk_p1;
        s1_p2    <= lk_p2;
        s1_p3    <= lk_p3;
      end
    end
  end

  if (PIPE != 0) begin : g_pipe
    logic         s2_valid, s2_final;
    logic [W-1:0] s2_p0, s2_p1, s2_p2, s2_p3;

    assign nxt_ready = !s2_valid || out_ready;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid <= 1'b0;
        s2_final <= 1'b0;
        s2_p0    <= '0;
        s2_p1    <= '0;
        s2_p2    <= '0;
        s2_p3    <= '0;
      end else if (nxt_ready) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_final <= s1_final;
          s2_p0    <= s1_p0;
          s2_p1    <= s1_p1;
          s2_p2    <= s1_p2;
          s2_p3    <= s1_p3;
        end
      end
    end

    assign out_valid = s2_valid;
    assign out_final = s2_final;
    assign out_p0    = s2_p0;
    assign out_p1    = s2_p1;
    assign out_p2    = s2_p2;
    assign out_p3    = s2_p3;
  end else begin : g_nopipe
    assign nxt_ready = out_ready;
    assign out_valid = s1_valid;
    assign out_final = s1_final;
    assign out_p0    = s1_p0;
    assign out_p1    = s1_p1;
    assign out_p2    = s1_p2;
    assign out_p3    = s1_p3;
  end

endmodule
